pokey_poly_noise: RTL and testbench

Polynomial noise source for the POKEY audio path, directly upstream of the per-channel noise filter.
- Generates the 4-bit, 5-bit and large (9- or 17-bit) pseudo-random bit streams that feed the filter's noise_4, noise_5 and noise_large inputs.
- Generates the 8-bit RANDOM register value.
- All LFSRs advance on a shared base-clock enable strobe.
- All LFSRs are forced to a known state by the SKCTL init condition.

---
 rtl/pokey_poly_noise.sv | 42 ++++
 tb/tb_pokey_poly_noise.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pokey_poly_noise.sv
// pokey_poly_noise: POKEY 4/5/9/17-bit polynomial noise LFSRs and RANDOM value
//   clk, reset_n      : clock, synchronous active-low reset
//   enable            : base-tick strobe; every LFSR shifts once when high
//   init              : SKCTL init; holds every LFSR at zero while high
//   poly9_select      : 1 = large noise and RANDOM from p9, 0 = from p17
//   noise_4, noise_5  : MSBs of the 4- and 5-bit LFSRs
//   noise_large       : MSB of the selected 9- or 17-bit LFSR
//   rand_out          : RANDOM register value (top 8 bits of selected LFSR)
module pokey_poly_noise (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       init,
  input  logic       poly9_select,
  output logic       noise_4,
  output logic       noise_5,
  output logic       noise_large,
  output logic [7:0] rand_out
);
  logic [3:0]  p4;
  logic [4:0]  p5;
  logic [8:0]  p9;
  logic [16:0] p17;
  // XNOR feedback keeps all-zero a running state, so reset/init to zero is safe
  always_ff @(posedge clk) begin
    if (!reset_n || init) begin
      p4  <= '0;
      p5  <= '0;
      p9  <= '0;
      p17 <= '0;
    end else if (enable) begin
      p4  <= {p4[2:0],   ~(p4[3]   ^ p4[2])};
      p5  <= {p5[3:0],   ~(p5[4]   ^ p5[2])};
      p9  <= {p9[7:0],   ~(p9[8]   ^ p9[4])};
      p17 <= {p17[15:0], ~(p17[16] ^ p17[13])};
    end
  end
  assign noise_4     = p4[3];
  assign noise_5     = p5[4];
  assign noise_large = poly9_select ? p9[8]   : p17[16];
  assign rand_out    = poly9_select ? p9[8:1] : p17[16:9];
endmodule

// File: tb/tb_pokey_poly_noise.sv
// tb_pokey_poly_noise: directed self-checking bench for pokey_poly_noise
module tb_pokey_poly_noise;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       init = 1'b0;
  logic       poly9_select = 1'b0;
  logic       noise_4, noise_5, noise_large;
  logic [7:0] rand_out;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0]  m4 = '0;
  logic [4:0]  m5 = '0;
  logic [8:0]  m9 = '0;
  logic [16:0] m17 = '0;
  bit         n4h[5] = '{0, 0, 0, 1, 1};
  bit         n5h[5] = '{0, 0, 0, 0, 1};
  logic [7:0] r9h[9] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0f, 8'h1f, 8'h3e, 8'h7c, 8'hf8};
  always #5 clk = ~clk;
  pokey_poly_noise dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .init(init),
    .poly9_select(poly9_select),
    .noise_4(noise_4),
    .noise_5(noise_5),
    .noise_large(noise_large),
    .rand_out(rand_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic r, input logic e, input logic i);
    reset_n = r;
    enable  = e;
    init    = i;
    @(posedge clk);
    if (!r || i) begin
      m4 = '0; m5 = '0; m9 = '0; m17 = '0;
    end else if (e) begin
      m4  = {m4[2:0],   ~(m4[3]   ^ m4[2])};
      m5  = {m5[3:0],   ~(m5[4]   ^ m5[2])};
      m9  = {m9[7:0],   ~(m9[8]   ^ m9[4])};
      m17 = {m17[15:0], ~(m17[16] ^ m17[13])};
    end
    #1;
  endtask
  task automatic check_model(input string tag);
    check({tag, ".n4"},   noise_4, m4[3]);
    check({tag, ".n5"},   noise_5, m5[4]);
    check({tag, ".nl"},   noise_large, poly9_select ? m9[8] : m17[16]);
    check({tag, ".rand"}, rand_out, poly9_select ? m9[8:1] : m17[16:9]);
  endtask
  task automatic check_zero(input string tag);
    check({tag, ".n4"},   noise_4, 0);
    check({tag, ".n5"},   noise_5, 0);
    check({tag, ".nl"},   noise_large, 0);
    check({tag, ".rand"}, rand_out, 0);
  endtask
  initial begin
    // reset state
    poly9_select = 1'b1;
    tick(0, 0, 0);
    tick(0, 1, 0);
    check_zero("reset");
    // continuous enable from reset, hand-derived sequences
    for (int k = 0; k < 9; k++) begin
      tick(1, 1, 0);
      if (k < 5) begin
        check($sformatf("n4_s%0d", k + 1), noise_4, n4h[k]);
        check($sformatf("n5_s%0d", k + 1), noise_5, n5h[k]);
      end
      check($sformatf("r9_s%0d", k + 1), rand_out, r9h[k]);
      check($sformatf("nl9_s%0d", k + 1), noise_large, k == 8);
    end
    // 17-bit source, hand-derived: after 15 shifts p17=0x07FFE, after 17 0x1FFF8
    poly9_select = 1'b0;
    tick(0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      tick(1, 1, 0);
      if (k == 15) check("r17_s15", rand_out, 8'h3f);
      if (k == 16) check("nl17_s16", noise_large, 0);
      if (k == 17) begin
        check("r17_s17", rand_out, 8'hff);
        check("nl17_s17", noise_large, 1);
      end
    end
    // full 9-bit period and p4/p5 periods against the reference model
    poly9_select = 1'b1;
    tick(0, 0, 0);
    for (int k = 1; k <= 511; k++) begin
      tick(1, 1, 0);
      check_model($sformatf("run_s%0d", k));
    end
    check("p9_period_rand", rand_out, 0);
    check("p9_period_nl", noise_large, 0);
    // enable pulsed one cycle in four
    tick(0, 0, 0);
    for (int c = 0; c < 40; c++) begin
      tick(1, (c % 4) == 0, 0);
      check_model($sformatf("pulse_c%0d", c));
      if ((c % 4) == 3 && c / 4 < 5) check($sformatf("pulse_n4_%0d", c / 4), noise_4, n4h[c / 4]);
    end
    // init held 10 cycles mid-run with enable high, then release with enable high
    for (int c = 0; c < 20; c++) tick(1, 1, 0);
    for (int c = 0; c < 10; c++) begin
      tick(1, 1, 1);
      check_zero($sformatf("init_c%0d", c));
    end
    for (int k = 0; k < 9; k++) begin
      tick(1, 1, 0);
      if (k < 5) begin
        check($sformatf("post_init_n4_%0d", k), noise_4, n4h[k]);
        check($sformatf("post_init_n5_%0d", k), noise_5, n5h[k]);
      end
      check($sformatf("post_init_r9_%0d", k), rand_out, r9h[k]);
    end
    // poly9_select toggling only re-muxes; p17 keeps running
    tick(0, 0, 0);
    poly9_select = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c == 50 || c == 160) poly9_select = 1'b1;
      if (c == 120 || c == 220) poly9_select = 1'b0;
      #1;
      check_model($sformatf("sel_mux_c%0d", c));
      tick(1, 1, 0);
    end
    check_model("sel_final");
    // reset wins over init and enable
    tick(0, 1, 1);
    check_zero("rst_prio");
    tick(1, 1, 0);
    check("rst_prio_first_n4", noise_4, 0);
    check_model("rst_prio_first");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
